sink_codeblock: RTL and testbench
=================================

Name: sink_codeblock

Overview:
- Writer-side program model for the compiler-optimization case study: a stutter-controlled FSM that stores values into a small array. It is the store counterpart of the read-only code blocks.
- Each state transition models one program step. `stutter_in` freezes the program so the asynchronous HyperLTL checker can align traces.
- It exposes the array contents and a per-step write observation (`wr_en`/`wr_idx`/`wr_data`) so that source and optimized variants can be compared trace-against-trace.

Parameters:
- IDX_W, 1, width of index inputs `j`, `arr_size` and internal loop counter; array depth N = 2**IDX_W (localparam).
- ARR_INIT, {N{1'b0}}, value loaded into `arr` at reset.

Ports:
- clk  input  1  single clock, all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- stutter_in  input  1  1 = hold program step this cycle.
- a  input  1  value stored to arr[0].
- b  input  1  value stored to indexed slot(s).
- j  input  IDX_W  start index.
- arr_size  input  IDX_W  last valid index.
- arr  output  N  array contents, registered.
- wr_en  output  1  a write happened on the last active edge.
- wr_idx  output  IDX_W  index of that write.
- wr_data  output  1  data of that write.
- stutter  output  1  registered copy of `stutter_in`.
- done  output  1  program reached terminal step.
- step  output  3  current computation step (observation).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: `step`=0, `arr`=ARR_INIT, `wr_en`=0, `wr_idx`=0, `wr_data`=0, `stutter`=0, `done`=0, internal latches and loop counter `i`=0.
- Reset has priority over everything, including mid-loop and during stutter.
- Every edge, `stutter`<=`stutter_in`, regardless of step.
- If `stutter_in`=1:
  - step, arr, i and latches hold.
  - `wr_en`<=0.
- If `stutter_in`=0, steps are:
  - 0: latch j→jl, arr_size→sl, a→al, b→bl; go to 1. All later steps use the latched values only; input changes after step 0 have no effect.
  - 1: go to 2 if jl<=sl (unsigned), else go to 4. No write.
  - 2: arr[0]<=al; i<=jl; write obs (0, al); go to 3.
  - 3 (loop): arr[i]<=bl; write obs (i, bl).
    - If i==sl, go to 6.
    - Else i<=i+1, stay in 3.
    - Loop runs sl-jl+1 iterations.
    - i never wraps because jl<=sl is guaranteed by step 1.
  - 4: arr[0]<=al; write obs (0, al); go to 5.
  - 5: arr[sl]<=bl; write obs (sl, bl); go to 6.
  - 6: terminal. `done`<=1 on the edge entering 6; stays 1 until reset. No writes. `stutter_in` is ignored except for the `stutter` output.
  - 7: unreachable; treat as 6.
- Write observation:
  - `wr_en`, `wr_idx`, `wr_data` are registered on the same edge as the array update.
  - They reflect that edge's write for exactly one cycle.
  - On non-writing active edges, `wr_en`<=0; `wr_idx`/`wr_data` hold their last values.
- Overwrite ordering:
  - If jl=0 (step 3) or sl=0 (step 5), the b-write overwrites arr[0] after the a-write.
  - Final arr[0]=bl.
  - Two distinct `wr_en` pulses are observed.
- Latency with no stutter and N=2:
  - True branch: 3 + (sl-jl+1) active edges to `done`.
  - False branch: 4 edges to `done`.
  - Each stutter cycle adds exactly one cycle.
- `step` output is the state register directly.

Test Plan:
- ARR_INIT=2'b10, j=0, arr_size=1, a=1, b=0, stutter_in=0 →
  - edge3: arr=2'b11, wr=(0,1).
  - edge4: arr=2'b10, wr=(0,0).
  - edge5: arr=2'b00, wr=(1,0), done=1.
  - Two consecutive pulses on index 0 are seen.
- ARR_INIT=0, j=1, arr_size=0, a=1, b=1 →
  - false branch, step sequence 0,1,4,5,6.
  - edge3: arr=2'b01.
  - edge4: wr=(0,1), done=1, final arr=2'b01.
- Scenario 1 with stutter_in=1 for 3 cycles after edge3 →
  - arr, step=3 and i frozen; wr_en=0.
  - stutter output high for 3 cycles, delayed by one cycle.
  - done rises at edge8 with the same final arr=2'b00.
- j=1, arr_size=1, a=0, b=1; toggle j/arr_size/a/b every cycle after edge1 →
  - result identical to the values latched at step 0: arr=2'b10, done at edge4.
- Assert reset during step 3 of scenario 1 →
  - next edge: arr=ARR_INIT, step=0, done=0, wr_en=0, stutter=0.
  - The program then reruns to the identical final state.
- Hold in step 6 for 10 cycles with random stutter_in and input changes →
  - arr, done=1 and step=6 stable; wr_en=0.
  - stutter tracks stutter_in with one-cycle delay.

Source files
------------

// File: rtl/sink_codeblock.sv
// sink_codeblock: writer-side program model. A small step machine latches its
// operands, then stores `a` to slot 0 and `b` to one or more indexed slots.
// Each active clock edge is one program step. `stutter_in` freezes the
// program for a cycle so traces of different variants can be aligned.
// Every store is mirrored onto a one-cycle write observation
// (wr_en/wr_idx/wr_data) so that source and optimized variants can be
// compared trace against trace.
module sink_codeblock #(
  parameter int                   IDX_W    = 1,
  parameter logic [2**IDX_W-1:0]  ARR_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stutter_in,
  input  logic                 a,
  input  logic                 b,
  input  logic [IDX_W-1:0]     j,
  input  logic [IDX_W-1:0]     arr_size,
  output logic [2**IDX_W-1:0]  arr,
  output logic                 wr_en,
  output logic [IDX_W-1:0]     wr_idx,
  output logic                 wr_data,
  output logic                 stutter,
  output logic                 done,
  output logic [2:0]           step
);

  localparam int N = 2**IDX_W;

  // Step encoding is visible on `step`, so the numeric values are fixed.
  typedef enum logic [2:0] {
    S_LATCH   = 3'd0,  // capture operands
    S_CHECK   = 3'd1,  // choose loop or two-store path
    S_TRUE_A  = 3'd2,  // loop path: store a to slot 0, seed counter
    S_LOOP    = 3'd3,  // loop path: store b to slot i, i = jl..sl
    S_FALSE_A = 3'd4,  // two-store path: store a to slot 0
    S_FALSE_B = 3'd5,  // two-store path: store b to slot sl
    S_DONE    = 3'd6,  // terminal
    S_UNUSED  = 3'd7   // unreachable; behaves like terminal
  } state_e;

  // Program state
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   jl_q, jl_d;
  logic [IDX_W-1:0]   sl_q, sl_d;
  logic               al_q, al_d;
  logic               bl_q, bl_d;
  logic [N-1:0]       arr_q, arr_d;

  // Observation state
  logic               wr_en_q, wr_en_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic               wr_data_q, wr_data_d;
  logic               stutter_q, stutter_d;
  logic               done_q, done_d;

  // Single write port chosen by the current step
  logic               wr_fire;
  logic [IDX_W-1:0]   wr_sel_idx;
  logic               wr_sel_data;

  // Next-step logic: at most one array store per active edge.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    jl_d        = jl_q;
    sl_d        = sl_q;
    al_d        = al_q;
    bl_d        = bl_q;
    wr_fire     = 1'b0;
    wr_sel_idx  = '0;
    wr_sel_data = 1'b0;

    if (!stutter_in) begin
      case (state_q)
        S_LATCH: begin
          // Operands are frozen here; later input changes are ignored.
          jl_d    = j;
          sl_d    = arr_size;
          al_d    = a;
          bl_d    = b;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          state_d = (jl_q <= sl_q) ? S_TRUE_A : S_FALSE_A;
        end
        S_TRUE_A: begin
          wr_fire     = 1'b1;
          wr_sel_idx  = '0;
          wr_sel_data = al_q;
          i_d         = jl_q;
          state_d     = S_LOOP;
        end
        S_LOOP: begin
          wr_fire     = 1'b1;
          wr_sel_idx  = i_q;
          wr_sel_data = bl_q;
          // jl <= sl was established in S_CHECK, so i reaches sl
          // before it could wrap.
          if (i_q == sl_q) begin
            state_d = S_DONE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end
        S_FALSE_A: begin
          wr_fire     = 1'b1;
          wr_sel_idx  = '0;
          wr_sel_data = al_q;
          state_d     = S_FALSE_B;
        end
        S_FALSE_B: begin
          wr_fire     = 1'b1;
          wr_sel_idx  = sl_q;
          wr_sel_data = bl_q;
          state_d     = S_DONE;
        end
        default: begin
          // S_DONE and the unreachable code both park without writing.
          state_d = state_q;
        end
      endcase
    end
  end

  // Observation next-state: pulse on a write, otherwise hold index/data.
  always_comb begin
    wr_en_d   = wr_fire;
    wr_idx_d  = wr_fire ? wr_sel_idx  : wr_idx_q;
    wr_data_d = wr_fire ? wr_sel_data : wr_data_q;
    stutter_d = stutter_in;
    done_d    = done_q | (state_d == S_DONE);
  end

  // Per-slot array update from the single write port.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      always_comb begin
        arr_d[gi] = (wr_fire && (wr_sel_idx == IDX_W'(gi))) ? wr_sel_data
                                                            : arr_q[gi];
      end
    end
  endgenerate

  // State registers; reset wins over stutter and every step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LATCH;
      i_q       <= '0;
      jl_q      <= '0;
      sl_q      <= '0;
      al_q      <= 1'b0;
      bl_q      <= 1'b0;
      arr_q     <= ARR_INIT;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 1'b0;
      stutter_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      jl_q      <= jl_d;
      sl_q      <= sl_d;
      al_q      <= al_d;
      bl_q      <= bl_d;
      arr_q     <= arr_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      stutter_q <= stutter_d;
      done_q    <= done_d;
    end
  end

  assign arr     = arr_q;
  assign wr_en   = wr_en_q;
  assign wr_idx  = wr_idx_q;
  assign wr_data = wr_data_q;
  assign stutter = stutter_q;
  assign done    = done_q;
  assign step    = state_q;

endmodule

// File: tb/tb_sink_codeblock.sv
// Testbench for sink_codeblock (IDX_W=1, ARR_INIT=2'b10).
// The reference model derives the list of stores a program performs from its
// operands, then replays that list one entry per non-stuttered edge.
module tb_sink_codeblock;

  localparam int          IW   = 1;
  localparam int          NN   = 2;
  localparam logic [1:0]  INIT = 2'b10;

  logic            clk;
  logic            reset;
  logic            stutter_in;
  logic            a;
  logic            b;
  logic [IW-1:0]   j;
  logic [IW-1:0]   arr_size;
  logic [NN-1:0]   arr;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic            wr_data;
  logic            stutter;
  logic            done;
  logic [2:0]      step;

  int tests_run = 0;
  int tests_failed = 0;

  sink_codeblock #(.IDX_W(IW), .ARR_INIT(INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .stutter_in (stutter_in),
    .a          (a),
    .b          (b),
    .j          (j),
    .arr_size   (arr_size),
    .arr        (arr),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .stutter    (stutter),
    .done       (done),
    .step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous reset with stutter_in high: reset must dominate.
  task automatic do_reset();
    reset      = 1'b1;
    stutter_in = 1'b1;
    a          = 1'($urandom_range(0, 1));
    b          = 1'($urandom_range(0, 1));
    j          = IW'($urandom_range(0, 1));
    arr_size   = IW'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("rst_arr",     32'(arr),     32'(INIT));
    chk("rst_step",    32'(step),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_idx",  32'(wr_idx),  32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_stutter", 32'(stutter), 32'd0);
    $display("[TB] reset: arr=%b step=%0d done=%0d", arr, step, done);
    reset = 1'b0;
  endtask

  // smode: 0 = no stutter, 1 = stutter on edges 4..6, 2 = random stutter.
  // stop_at > 0 ends the run after that edge (used to reset mid-program).
  // exp_done_edge > 0 checks the edge on which done first rises.
  task automatic run_case(input logic jj, input logic ss, input logic aa, input logic bb,
                          input int smode, input bit toggle, input int stop_at,
                          input int hold_after, input int exp_done_edge, input string tag);
    int          widx[$];
    logic        wdat[$];
    bit          loop_path;
    int          nw;
    logic [1:0]  marr;
    int          n;
    bit          mdone;
    int          held;
    logic        m_wr_en;
    logic        m_idx;
    logic        m_dat;
    int          m_step;
    logic        stin;
    int          dut_done_edge;

    // Stores the program performs, in order.
    loop_path = (jj <= ss);
    widx.push_back(0); wdat.push_back(aa);
    if (loop_path) begin
      for (int k = int'(jj); k <= int'(ss); k++) begin
        widx.push_back(k); wdat.push_back(bb);
      end
    end else begin
      widx.push_back(int'(ss)); wdat.push_back(bb);
    end
    nw = widx.size();

    marr = INIT; n = 0; mdone = 1'b0; held = 0;
    m_idx = 1'b0; m_dat = 1'b0; m_step = 0;
    dut_done_edge = -1;

    for (int ecnt = 1; ecnt <= 200; ecnt++) begin
      if (mdone)           stin = 1'($urandom_range(0, 1));
      else if (smode == 1) stin = (ecnt >= 4 && ecnt <= 6);
      else if (smode == 2) stin = ($urandom_range(0, 3) == 0);
      else                 stin = 1'b0;

      if (n == 0) begin
        j = jj; arr_size = ss; a = aa; b = bb;
      end else if (toggle || mdone) begin
        j = ~j; arr_size = ~arr_size; a = ~a; b = 1'($urandom_range(0, 1));
      end
      stutter_in = stin;
      @(posedge clk); #1;

      m_wr_en = 1'b0;
      if (!stin && !mdone) begin
        n++;
        if (n >= 3) begin
          marr[widx[n-3]] = wdat[n-3];
          m_wr_en = 1'b1;
          m_idx   = 1'(widx[n-3]);
          m_dat   = wdat[n-3];
          if (n - 2 == nw) mdone = 1'b1;
        end
        if (n == 1)            m_step = 1;
        else if (n == 2)       m_step = loop_path ? 2 : 4;
        else if (n - 2 == nw)  m_step = 6;
        else                   m_step = loop_path ? 3 : 5;
      end

      if (done === 1'b1 && dut_done_edge < 0) dut_done_edge = ecnt;

      $display("[TB] %s e%0d si=%0d: arr=%b step=%0d wr=%0d(%0d,%0d) done=%0d st=%0d",
               tag, ecnt, stin, arr, step, wr_en, wr_idx, wr_data, done, stutter);
      chk({tag, "_arr"},     32'(arr),     32'(marr));
      chk({tag, "_step"},    32'(step),    32'(m_step));
      chk({tag, "_wr_en"},   32'(wr_en),   32'(m_wr_en));
      chk({tag, "_wr_idx"},  32'(wr_idx),  32'(m_idx));
      chk({tag, "_wr_data"}, 32'(wr_data), 32'(m_dat));
      chk({tag, "_done"},    32'(done),    32'(mdone));
      chk({tag, "_stutter"}, 32'(stutter), 32'(stin));

      if (stop_at > 0 && ecnt == stop_at) return;
      if (mdone) begin
        if (held >= hold_after) break;
        held++;
      end
      if (ecnt == 200) chk({tag, "_timeout"}, 32'(mdone), 32'd1);
    end

    if (exp_done_edge > 0)
      chk({tag, "_done_edge"}, 32'(dut_done_edge), 32'(exp_done_edge));
  endtask

  initial begin
    reset = 1'b1; stutter_in = 1'b0; a = 1'b0; b = 1'b0; j = '0; arr_size = '0;

    // Loop path with jl=0: two pulses on slot 0, then slot 1; hold in done.
    do_reset();
    run_case(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 10, 5, "s1");

    // Two-store path (j > arr_size).
    do_reset();
    run_case(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 0, 4, "s2");

    // Scenario 1 with three stutter cycles after edge 3.
    do_reset();
    run_case(1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 0, 0, 8, "s3");

    // Inputs toggled after latching must have no effect.
    do_reset();
    run_case(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 0, 4, "s4");

    // Reset in the middle of the loop, then rerun.
    do_reset();
    run_case(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 4, 0, 0, "s5a");
    do_reset();
    run_case(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 2, 5, "s5b");

    // Random operands, random stutter, toggling inputs.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2, 1'b1, 0, 3, 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
